difftest_commit_tracker: RTL and testbench

// Sits directly upstream of the DPI difftest register probe. Shadows the

---
 rtl/difftest_commit_tracker_pkg.sv | 19 +
 rtl/difftest_gpr_shadow.sv | 36 +++
 rtl/difftest_commit_tracker.sv | 132 +++++++++++++
 tb/tb_difftest_commit_tracker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_commit_tracker_pkg.sv
// Shared definitions for the difftest commit tracker: data widths, the PC
// value after reset, the tracker FSM state encoding and the a0 register index.
package difftest_commit_tracker_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NR_GPR   = 32;
  localparam int unsigned CNT_W    = 64;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned A0       = 10;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

endpackage

// File: rtl/difftest_gpr_shadow.sv
// Shadow copy of the architectural GPR file as seen at commit.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   wr_en        : write strobe (already qualified by an accepted retire)
//   wr_idx       : destination register index; index 0 is never stored
//   wr_data      : value written into the selected shadow register
//   gpr_flat     : all registers flattened, register i at [i*XLEN +: XLEN]
module difftest_gpr_shadow
  import difftest_commit_tracker_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [XLEN-1:0]          wr_data,
  output logic [NR_GPR*XLEN-1:0]   gpr_flat
);

  // x0 is hardwired zero, so it has no storage at all.
  assign gpr_flat[XLEN-1:0] = '0;

  for (genvar i = 1; i < NR_GPR; i++) begin : g_gpr
    logic [XLEN-1:0] gpr_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        gpr_q <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        gpr_q <= wr_data;
      end
    end

    assign gpr_flat[i*XLEN +: XLEN] = gpr_q;
  end

endmodule

// File: rtl/difftest_commit_tracker.sv
// Shadows architectural state (GPRs plus next PC) at instruction commit for
// the difftest register probe, and reports commit pulses, retire count,
// ebreak halt status and a no-commit watchdog.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   cmt_valid      : core presents a retiring instruction
//   cmt_ready      : tracker accepts retires (RUN state only)
//   cmt_npc        : PC of the next instruction after this retire
//   cmt_rd_wen     : retire writes rd
//   cmt_rd         : destination register index
//   cmt_rd_wdata   : rd write data
//   cmt_ebreak     : retiring instruction is ebreak
//   gpr_flat       : slot i at [i*XLEN +: XLEN], slot NR_GPR is the PC
//   dt_commit      : one-cycle pulse, gpr_flat reflects a new retire
//   dt_inst_cnt    : retired instructions since reset
//   halted         : ebreak retired (sticky)
//   halt_code      : a0 value at halt
//   wdog_timeout   : no commit within WDOG_CYCLES (sticky)
module difftest_commit_tracker
  import difftest_commit_tracker_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmt_valid,
  output logic                          cmt_ready,
  input  logic [XLEN-1:0]               cmt_npc,
  input  logic                          cmt_rd_wen,
  input  logic [IDX_W-1:0]              cmt_rd,
  input  logic [XLEN-1:0]               cmt_rd_wdata,
  input  logic                          cmt_ebreak,
  output logic [(NR_GPR+1)*XLEN-1:0]    gpr_flat,
  output logic                          dt_commit,
  output logic [CNT_W-1:0]              dt_inst_cnt,
  output logic                          halted,
  output logic [XLEN-1:0]               halt_code,
  output logic                          wdog_timeout
);

  localparam int unsigned WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  state_e                 state_q;
  logic                   ready_q;
  logic                   commit_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   halted_q;
  logic [XLEN-1:0]        halt_code_q;
  logic                   wdog_to_q;
  logic [WDOG_W-1:0]      wdog_q;
  logic [XLEN-1:0]        pc_q;

  logic                   accept_c;
  logic                   gpr_wen_c;
  logic [XLEN-1:0]        a0_post_c;
  logic [NR_GPR*XLEN-1:0] gpr_cur;

  // ready_q is 1 exactly while state_q is RUN, so it doubles as the accept gate.
  assign accept_c  = cmt_valid & ready_q;
  assign gpr_wen_c = accept_c & cmt_rd_wen;

  // a0 as it will be after this retire: a same-retire write to x10 wins.
  assign a0_post_c = (cmt_rd_wen && (cmt_rd == IDX_W'(A0))) ? cmt_rd_wdata
                                                             : gpr_cur[A0*XLEN +: XLEN];

  difftest_gpr_shadow u_gpr_shadow (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (gpr_wen_c),
    .wr_idx   (cmt_rd),
    .wr_data  (cmt_rd_wdata),
    .gpr_flat (gpr_cur)
  );

  // Tracker FSM with retire count, halt capture and watchdog.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      commit_q    <= 1'b0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      halt_code_q <= '0;
      wdog_to_q   <= 1'b0;
      wdog_q      <= '0;
      pc_q        <= RESET_PC;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
          wdog_q  <= '0;
        end
        ST_RUN: begin
          if (accept_c) begin
            // An accept in the expiry cycle still clears the watchdog.
            commit_q <= 1'b1;
            cnt_q    <= cnt_q + CNT_W'(1);
            pc_q     <= cmt_npc;
            wdog_q   <= '0;
            if (cmt_ebreak) begin
              state_q     <= ST_HALT;
              ready_q     <= 1'b0;
              halted_q    <= 1'b1;
              halt_code_q <= a0_post_c;
            end
          end else if (wdog_q == WDOG_LAST) begin
            state_q   <= ST_TIMEOUT;
            ready_q   <= 1'b0;
            wdog_to_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        default: begin
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmt_ready    = ready_q;
  assign dt_commit    = commit_q;
  assign dt_inst_cnt  = cnt_q;
  assign halted       = halted_q;
  assign halt_code    = halt_code_q;
  assign wdog_timeout = wdog_to_q;
  assign gpr_flat     = {pc_q, gpr_cur};

endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Directed bench for difftest_commit_tracker (watchdog shortened to 8 cycles).
module tb_difftest_commit_tracker;
  import difftest_commit_tracker_pkg::*;

  localparam int unsigned WDOG = 8;

  logic                        clock;
  logic                        reset;
  logic                        cmt_valid;
  logic                        cmt_ready;
  logic [XLEN-1:0]             cmt_npc;
  logic                        cmt_rd_wen;
  logic [IDX_W-1:0]            cmt_rd;
  logic [XLEN-1:0]             cmt_rd_wdata;
  logic                        cmt_ebreak;
  logic [(NR_GPR+1)*XLEN-1:0]  gpr_flat;
  logic                        dt_commit;
  logic [CNT_W-1:0]            dt_inst_cnt;
  logic                        halted;
  logic [XLEN-1:0]             halt_code;
  logic                        wdog_timeout;

  int vectors = 0;
  int miscompares = 0;

  difftest_commit_tracker #(.WDOG_CYCLES(WDOG)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmt_valid    (cmt_valid),
    .cmt_ready    (cmt_ready),
    .cmt_npc      (cmt_npc),
    .cmt_rd_wen   (cmt_rd_wen),
    .cmt_rd       (cmt_rd),
    .cmt_rd_wdata (cmt_rd_wdata),
    .cmt_ebreak   (cmt_ebreak),
    .gpr_flat     (gpr_flat),
    .dt_commit    (dt_commit),
    .dt_inst_cnt  (dt_inst_cnt),
    .halted       (halted),
    .halt_code    (halt_code),
    .wdog_timeout (wdog_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [XLEN-1:0] slot(input int i);
    return gpr_flat[i*XLEN +: XLEN];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic wen, input int rd,
                       input logic [XLEN-1:0] wd, input logic [XLEN-1:0] npc,
                       input logic eb);
    cmt_valid    = v;
    cmt_rd_wen   = wen;
    cmt_rd       = IDX_W'(rd);
    cmt_rd_wdata = wd;
    cmt_npc      = npc;
    cmt_ebreak   = eb;
  endtask

  // Reset, release, and step past IDLE so the tracker is in RUN.
  task automatic reset_to_run();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic bad;
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    bad = 1'b0;
    for (int i = 0; i < NR_GPR; i++) if (slot(i) !== '0) bad = 1'b1;
    vectors++;
    if (bad) begin miscompares++; $display("FAIL reset_gprs: some GPR slot nonzero"); end
    vectors++;
    if (slot(NR_GPR) !== 64'h8000_0000) begin
      miscompares++; $display("FAIL reset_pc: got %h want 80000000", slot(NR_GPR));
    end
    vectors++;
    if ({cmt_ready, dt_commit, halted, wdog_timeout} !== 4'b0 || dt_inst_cnt !== '0 || halt_code !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rdy=%b cmt=%b hlt=%b wdog=%b cnt=%0d code=%h want all 0",
               cmt_ready, dt_commit, halted, wdog_timeout, dt_inst_cnt, halt_code);
    end
    reset = 1'b0;
    #2;
    vectors++;
    if (cmt_ready !== 1'b0) begin miscompares++; $display("FAIL ready_cycle1: got %b want 0", cmt_ready); end
    tick();
    vectors++;
    if (cmt_ready !== 1'b1) begin miscompares++; $display("FAIL ready_cycle2: got %b want 1", cmt_ready); end
  endtask

  task automatic test_single_commit();
    drive(1'b1, 1'b1, 5, 64'hDEAD, 64'h8000_0004, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    vectors++;
    if (dt_commit !== 1'b1 || slot(5) !== 64'hDEAD || slot(NR_GPR) !== 64'h8000_0004 || dt_inst_cnt !== 64'd1) begin
      miscompares++;
      $display("FAIL single_commit: cmt=%b x5=%h pc=%h cnt=%0d want 1 dead 80000004 1",
               dt_commit, slot(5), slot(NR_GPR), dt_inst_cnt);
    end
    tick();
    vectors++;
    if (dt_commit !== 1'b0 || dt_inst_cnt !== 64'd1) begin
      miscompares++; $display("FAIL commit_pulse_end: cmt=%b cnt=%0d want 0 1", dt_commit, dt_inst_cnt);
    end
  endtask

  task automatic test_x0_write();
    drive(1'b1, 1'b1, 0, 64'h1234, 64'h8000_0008, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    vectors++;
    if (slot(0) !== '0 || dt_commit !== 1'b1 || dt_inst_cnt !== 64'd2 || slot(NR_GPR) !== 64'h8000_0008) begin
      miscompares++;
      $display("FAIL x0_write: x0=%h cmt=%b cnt=%0d pc=%h want 0 1 2 80000008",
               slot(0), dt_commit, dt_inst_cnt, slot(NR_GPR));
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] data [3] = '{64'h111, 64'h2222, 64'h3_3333};
    reset_to_run();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, k + 1, data[k], 64'h8000_0100 + XLEN'(4 * k), 1'b0);
      tick();
      vectors++;
      if (dt_commit !== 1'b1 || dt_inst_cnt !== CNT_W'(k + 1) || slot(k + 1) !== data[k]) begin
        miscompares++;
        $display("FAIL b2b_%0d: cmt=%b cnt=%0d x%0d=%h want 1 %0d %h",
                 k, dt_commit, dt_inst_cnt, k + 1, slot(k + 1), k + 1, data[k]);
      end
    end
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    tick();
    vectors++;
    if (dt_commit !== 1'b0 || dt_inst_cnt !== 64'd3 || slot(NR_GPR) !== 64'h8000_0108 || slot(1) !== 64'h111) begin
      miscompares++;
      $display("FAIL b2b_end: cmt=%b cnt=%0d pc=%h x1=%h want 0 3 80000108 111",
               dt_commit, dt_inst_cnt, slot(NR_GPR), slot(1));
    end
  endtask

  task automatic test_ebreak();
    drive(1'b1, 1'b1, 10, 64'h7, 64'h8000_0200, 1'b1);
    tick();
    vectors++;
    if (halted !== 1'b1 || halt_code !== 64'h7 || cmt_ready !== 1'b0 || dt_commit !== 1'b1 || dt_inst_cnt !== 64'd4) begin
      miscompares++;
      $display("FAIL ebreak: hlt=%b code=%h rdy=%b cmt=%b cnt=%0d want 1 7 0 1 4",
               halted, halt_code, cmt_ready, dt_commit, dt_inst_cnt);
    end
    drive(1'b1, 1'b1, 10, 64'h99, 64'h8000_0300, 1'b0);
    tick();
    tick();
    tick();
    vectors++;
    if (dt_inst_cnt !== 64'd4 || dt_commit !== 1'b0 || slot(10) !== 64'h7 || slot(NR_GPR) !== 64'h8000_0200 || halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_frozen: cnt=%0d cmt=%b x10=%h pc=%h hlt=%b want 4 0 7 80000200 1",
               dt_inst_cnt, dt_commit, slot(10), slot(NR_GPR), halted);
    end
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
  endtask

  task automatic test_ebreak_old_a0();
    reset_to_run();
    drive(1'b1, 1'b1, 10, 64'h55, 64'h8000_0004, 1'b0);
    tick();
    drive(1'b1, 1'b0, 10, 64'hBAD, 64'h8000_0008, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    vectors++;
    if (halted !== 1'b1 || halt_code !== 64'h55 || slot(10) !== 64'h55 || dt_inst_cnt !== 64'd2) begin
      miscompares++;
      $display("FAIL ebreak_old_a0: hlt=%b code=%h x10=%h cnt=%0d want 1 55 55 2",
               halted, halt_code, slot(10), dt_inst_cnt);
    end
  endtask

  task automatic test_watchdog();
    logic early;
    reset_to_run();
    early = 1'b0;
    for (int k = 1; k < WDOG; k++) begin
      tick();
      if (wdog_timeout !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early) begin miscompares++; $display("FAIL wdog_early: timeout before %0d RUN cycles", WDOG); end
    tick();
    vectors++;
    if (wdog_timeout !== 1'b1 || cmt_ready !== 1'b0) begin
      miscompares++; $display("FAIL wdog_expire: wdog=%b rdy=%b want 1 0", wdog_timeout, cmt_ready);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (wdog_timeout !== 1'b0 || cmt_ready !== 1'b0 || dt_inst_cnt !== '0 || slot(NR_GPR) !== 64'h8000_0000 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_timeout: wdog=%b rdy=%b cnt=%0d pc=%h hlt=%b want 0 0 0 80000000 0",
               wdog_timeout, cmt_ready, dt_inst_cnt, slot(NR_GPR), halted);
    end
    reset = 1'b0;
  endtask

  task automatic test_wdog_accept_wins();
    logic early;
    reset_to_run();
    for (int k = 1; k < WDOG; k++) tick();
    drive(1'b1, 1'b1, 3, 64'hAB, 64'h8000_0004, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    vectors++;
    if (wdog_timeout !== 1'b0 || dt_commit !== 1'b1 || cmt_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wdog_accept_wins: wdog=%b cmt=%b rdy=%b want 0 1 1", wdog_timeout, dt_commit, cmt_ready);
    end
    early = 1'b0;
    for (int k = 1; k < WDOG; k++) begin
      tick();
      if (wdog_timeout !== 1'b0) early = 1'b1;
    end
    tick();
    vectors++;
    if (early || wdog_timeout !== 1'b1) begin
      miscompares++; $display("FAIL wdog_rearm: early=%b wdog=%b want 0 1", early, wdog_timeout);
    end
  endtask

  task automatic test_reset_mid_commit();
    reset_to_run();
    drive(1'b1, 1'b1, 5, 64'hF00D, 64'h8000_0040, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    reset = 1'b1;
    #1;
    vectors++;
    if (dt_commit !== 1'b0 || dt_inst_cnt !== '0 || slot(5) !== '0 || slot(NR_GPR) !== 64'h8000_0000) begin
      miscompares++;
      $display("FAIL reset_mid_commit: cmt=%b cnt=%0d x5=%h pc=%h want 0 0 0 80000000",
               dt_commit, dt_inst_cnt, slot(5), slot(NR_GPR));
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    test_reset();
    test_single_commit();
    test_x0_write();
    test_back_to_back();
    test_ebreak();
    test_ebreak_old_a0();
    test_watchdog();
    test_wdog_accept_wins();
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
